// File: rtl/muldiv_ctrl.sv
// HI/LO sequencer for the multiply/divide unit: results are captured at the start edge and committed after MULT_CYCLES/DIV_CYCLES.
// stall_md is the only combinational output; it holds ID while an md op is starting or running.
module muldiv_ctrl #(
   parameter int MULT_CYCLES        = 5,
   parameter int DIV_CYCLES         = 10,
   parameter bit CHECK_START_IN_RUN = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start_E,
   input  logic [2:0]  md_op_E,
   input  logic [31:0] srcA_E,
   input  logic [31:0] srcB_E,
   input  logic        md_use_D,
   output logic        busy,
   output logic        stall_md,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

   localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_CYCLES);
   localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [31:0]      pend_hi;
   logic [31:0]      pend_lo;
   logic             pend_skip;

   logic [63:0] prod_s;
   logic [63:0] prod_u;
   logic        div_signed;
   logic        div_zero;
   logic [31:0] abs_a;
   logic [31:0] abs_b;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic [31:0] q_mag;
   logic [31:0] r_mag;
   logic [31:0] quo;
   logic [31:0] rem;

   always_comb begin
      prod_s     = {{32{srcA_E[31]}}, srcA_E} * {{32{srcB_E[31]}}, srcB_E};
      prod_u     = {32'd0, srcA_E} * {32'd0, srcB_E};

      // One unsigned divider serves both flavours; signed ops divide magnitudes and fix signs after.
      div_signed = (md_op_E == OP_DIV);
      div_zero   = (srcB_E == 32'd0);
      abs_a      = srcA_E[31] ? -srcA_E : srcA_E;
      abs_b      = srcB_E[31] ? -srcB_E : srcB_E;
      dividend   = div_signed ? abs_a : srcA_E;
      divisor    = div_signed ? abs_b : srcB_E;
      if (div_zero) begin
         divisor = 32'd1;
      end
      q_mag      = dividend / divisor;
      r_mag      = dividend % divisor;
      quo        = (div_signed && (srcA_E[31] ^ srcB_E[31])) ? -q_mag : q_mag;
      rem        = (div_signed && srcA_E[31]) ? -r_mag : r_mag;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         busy      <= 1'b0;
         HI        <= 32'd0;
         LO        <= 32'd0;
         pend_hi   <= 32'd0;
         pend_lo   <= 32'd0;
         pend_skip <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start_E) begin
                  case (md_op_E)
                     OP_MULT, OP_MULTU: begin
                        {pend_hi, pend_lo} <= (md_op_E == OP_MULT) ? prod_s : prod_u;
                        pend_skip          <= 1'b0;
                        cnt                <= MULT_CNT;
                        busy               <= 1'b1;
                        state              <= RUN;
                     end
                     OP_DIV, OP_DIVU: begin
                        pend_hi   <= rem;
                        pend_lo   <= quo;
                        pend_skip <= div_zero;
                        cnt       <= DIV_CNT;
                        busy      <= 1'b1;
                        state     <= RUN;
                     end
                     OP_MTHI: HI <= srcA_E;
                     OP_MTLO: LO <= srcA_E;
                     default: ;
                  endcase
               end
            end
            RUN: begin
               if (cnt == CNT_ONE) begin
                  // A zero divisor still burns the full window but leaves HI/LO alone.
                  if (!pend_skip) begin
                     HI <= pend_hi;
                     LO <= pend_lo;
                  end
                  cnt   <= '0;
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  cnt <= cnt - CNT_ONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign stall_md = md_use_D & (start_E | busy);

   always @(posedge clk) begin
      if (CHECK_START_IN_RUN && !reset && state == RUN) begin
         assert (!start_E);
      end
   end

endmodule
